vga_fb_writer: RTL and testbench

// - Write side of the 32K x 16 video RAM that the VGA display path scans out.
// - Accepts pixel-plot and full-screen-fill commands over a valid/ready handshake.
// - Plot: read-modify-write of one byte lane. Fill: writes every framebuffer word.
// - Framebuffer: 320x200, 8-bit rrr_ggg_bb, two pixels per 16-bit word.

---
 rtl/vga_fb_writer_if.sv | 34 +++
 rtl/vga_fb_writer.sv | 124 ++++++++++++
 tb/tb_vga_fb_writer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_writer_if.sv
// Command and video-RAM signal bundle for vga_fb_writer.
//   slave  : writer side (takes commands, drives the RAM write/read strobes)
//   master : environment side (issues commands, owns the RAM read data)
// Signals:
//   enable, cmd_valid, cmd_op, cmd_x[8:0], cmd_y[7:0], cmd_color[7:0] -> writer
//   cmd_ready, busy, err                                             <- writer
//   mem_addr[14:0], mem_re, mem_we, mem_wdata[15:0]                  <- writer
//   mem_rdata[15:0]                                                  -> writer
interface vga_fb_writer_if;
    logic        enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_color;
    logic        busy;
    logic        err;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_we;
    logic [15:0] mem_wdata;

    modport slave (
        input  enable, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, mem_rdata,
        output cmd_ready, busy, err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output enable, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, mem_rdata,
        input  cmd_ready, busy, err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_writer.sv
// Write side of the 32K x 16 video RAM scanned out by the VGA display path.
// Accepts plot-pixel (read-modify-write of one byte lane) and fill-screen
// commands over a valid/ready handshake. Framebuffer is FB_W x FB_H pixels of
// rrr_ggg_bb, two pixels per word: even x in [15:8], odd x in [7:0].
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - vga_fb_writer_if.slave: command handshake, status, RAM port
module vga_fb_writer #(
    parameter int unsigned FB_W     = 320,
    parameter int unsigned FB_H     = 200,
    parameter int unsigned FB_WORDS = FB_W * FB_H / 2
) (
    input  logic             clk,
    input  logic             reset,
    vga_fb_writer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FILL
    } state_t;

    localparam logic [14:0] LAST_ADDR = 15'(FB_WORDS - 1);

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        lane_q, lane_d;
    logic [7:0]  color_q, color_d;

    logic        cmd_ready;
    logic        accept;
    logic [16:0] widx;
    logic        in_range;
    logic [15:0] merged;

    assign cmd_ready = (state_q == IDLE) && bus.enable;
    assign accept    = bus.cmd_valid && cmd_ready;

    // Pixel index; constant multiply reduces to (y<<8)+(y<<6)+x for FB_W=320.
    assign widx     = 17'(bus.cmd_y) * 17'(FB_W) + 17'(bus.cmd_x);
    assign in_range = (32'(bus.cmd_x) < FB_W) && (32'(bus.cmd_y) < FB_H)
                   && (32'(widx) < 2 * FB_WORDS);

    // Read data arrives in WR, so the merge is combinational from mem_rdata.
    assign merged = lane_q ? {bus.mem_rdata[15:8], color_q}
                           : {color_q, bus.mem_rdata[7:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        lane_d  = lane_q;
        color_d = color_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    color_d = bus.cmd_color;
                    if (bus.cmd_op) begin
                        state_d = FILL;
                        addr_d  = '0;
                        wdata_d = {bus.cmd_color, bus.cmd_color};
                    end else if (in_range) begin
                        state_d = RD;
                        addr_d  = widx[15:1];
                        lane_d  = widx[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
                state_d = IDLE;
                // Keep the written word so mem_wdata holds it once idle.
                wdata_d = merged;
            end
            FILL: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + 15'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            lane_q  <= 1'b0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
            color_q <= color_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_re    = (state_q == RD);
    assign bus.mem_we    = (state_q == WR) || (state_q == FILL);
    assign bus.mem_wdata = (state_q == WR) ? merged : wdata_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Self-checking bench for vga_fb_writer: directed cases plus randomized plots
// against a pixel-level framebuffer model.
module tb_vga_fb_writer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_fb_writer_if bus ();

    vga_fb_writer #(
        .FB_W    (320),
        .FB_H    (200),
        .FB_WORDS(32000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Video RAM: one-cycle read latency, plus a bench-side poke port.
    logic [15:0] ram [0:32767];
    logic        poke_en;
    logic [14:0] poke_addr;
    logic [15:0] poke_data;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (poke_en)    ram[poke_addr]    <= poke_data;
        if (bus.mem_re) bus.mem_rdata     <= ram[bus.mem_addr];
    end

    // Reference framebuffer contents.
    logic [15:0] exp_ram [0:32767];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        poke_en   = 1'b1;
        poke_addr = a[14:0];
        poke_data = d;
        step();
        poke_en = 1'b0;
        exp_ram[a] = d;
    endtask

    // Waits (bounded) for cmd_ready with cmd_valid high, then advances to T+1
    // and scrambles the command fields, which must have been latched.
    task automatic wait_accept();
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", 32'(n < 50), 1);
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'($urandom);
        bus.cmd_x     = 9'($urandom);
        bus.cmd_y     = 8'($urandom);
        bus.cmd_color = 8'($urandom);
    endtask

    task automatic plot_and_check(input int x, input int y, input logic [7:0] c);
        int          a;
        logic [15:0] old_w, new_w;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = x[8:0];
        bus.cmd_y     = y[7:0];
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        wait_accept();
        if (x < 320 && y < 200) begin
            a     = (y * 320 + x) / 2;
            old_w = exp_ram[a];
            new_w = (x % 2 == 0) ? {c, old_w[7:0]} : {old_w[15:8], c};
            check("rd_re", bus.mem_re, 1);
            check("rd_we", bus.mem_we, 0);
            check("rd_addr", bus.mem_addr, a);
            check("rd_busy", bus.busy, 1);
            check("rd_ready", bus.cmd_ready, 0);
            check("rd_err", bus.err, 0);
            step();
            check("wr_we", bus.mem_we, 1);
            check("wr_re", bus.mem_re, 0);
            check("wr_addr", bus.mem_addr, a);
            check("wr_wdata", bus.mem_wdata, new_w);
            step();
            exp_ram[a] = new_w;
            check("done_ready", bus.cmd_ready, bus.enable);
            check("done_busy", bus.busy, 0);
            check("done_we", bus.mem_we, 0);
            check("plot_ram", ram[a], new_w);
        end else begin
            check("oor_err", bus.err, 1);
            check("oor_re", bus.mem_re, 0);
            check("oor_we", bus.mem_we, 0);
            check("oor_ready", bus.cmd_ready, 1);
            check("oor_busy", bus.busy, 0);
            step();
            check("oor_err_clr", bus.err, 0);
            check("oor_re2", bus.mem_re, 0);
            check("oor_we2", bus.mem_we, 0);
        end
    endtask

    task automatic compare_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < 32000; i++) begin
            if (ram[i] !== exp_ram[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          x, y, n, bad_addr, bad_data, bad_flags, bad_re;
        logic [7:0]  c;
        int          acc [$];

        reset         = 1'b1;
        poke_en       = 1'b0;
        poke_addr     = '0;
        poke_data     = '0;
        bus.enable    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_color = '0;
        step();
        step();
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_re", bus.mem_re, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        reset      = 1'b0;
        bus.enable = 1'b1;
        step();
        check("idle_ready", bus.cmd_ready, 1);

        // Directed lane cases.
        poke(0, 16'hAAAA);
        plot_and_check(0, 0, 8'h1C);
        check("dir_ram0", ram[0], 16'h1CAA);
        poke(16'h00A0, 16'h1234);
        plot_and_check(1, 1, 8'hE3);
        check("dir_ram_a0", ram[16'h00A0], 16'h12E3);

        // Last pixel and out-of-range boundaries.
        poke(31999, 16'h5555);
        plot_and_check(319, 199, 8'hC7);
        check("dir_last", ram[31999], 16'h55C7);
        plot_and_check(320, 0, 8'h11);
        plot_and_check(0, 200, 8'h22);

        // Randomized plots, in and out of range.
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, 335);
            y = $urandom_range(0, 215);
            c = 8'($urandom);
            if (x < 320 && y < 200) poke((y * 320 + x) / 2, 16'($urandom));
            plot_and_check(x, y, c);
        end

        // Back-to-back plots with cmd_valid held.
        poke(805, 16'hBEEF);
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = 9'd10;
        bus.cmd_y     = 8'd5;
        bus.cmd_color = 8'h77;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (bus.cmd_ready) acc.push_back(k);
            step();
        end
        bus.cmd_valid = 1'b0;
        step();
        step();
        check("b2b_count", acc.size(), 3);
        if (acc.size() == 3) begin
            check("b2b_gap1", acc[1] - acc[0], 3);
            check("b2b_gap2", acc[2] - acc[1], 3);
        end
        exp_ram[805] = 16'h77EF;
        check("b2b_ram", ram[805], 16'h77EF);

        // enable dropped during RD: write still completes, no new accept.
        poke(321, 16'h0F0F);
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = 9'd3;
        bus.cmd_y     = 8'd2;
        bus.cmd_color = 8'h44;
        bus.cmd_valid = 1'b1;
        wait_accept();
        bus.enable = 1'b0;
        check("en_rd_re", bus.mem_re, 1);
        step();
        check("en_wr_we", bus.mem_we, 1);
        check("en_wr_wdata", bus.mem_wdata, 16'h0F44);
        step();
        exp_ram[321] = 16'h0F44;
        check("en_ready_low", bus.cmd_ready, 0);
        check("en_busy", bus.busy, 0);
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = 9'd4;
        bus.cmd_y     = 8'd2;
        bus.cmd_color = 8'h55;
        bus.cmd_valid = 1'b1;
        bad_re = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.mem_re || bus.mem_we || bus.busy) bad_re++;
        end
        check("en_no_accept", bad_re, 0);
        bus.cmd_valid = 1'b0;
        bus.enable    = 1'b1;
        plot_and_check(4, 2, 8'h55);

        // Full fill.
        bus.cmd_op    = 1'b1;
        bus.cmd_x     = 9'($urandom);
        bus.cmd_y     = 8'($urandom);
        bus.cmd_color = 8'h03;
        bus.cmd_valid = 1'b1;
        wait_accept();
        n = 0; bad_addr = 0; bad_data = 0; bad_flags = 0;
        while (bus.mem_we && n < 33000) begin
            if (bus.mem_addr !== n[14:0]) bad_addr++;
            if (bus.mem_wdata !== 16'h0303) bad_data++;
            if (!bus.busy || bus.cmd_ready || bus.mem_re) bad_flags++;
            n++;
            step();
        end
        check("fill_count", n, 32000);
        check("fill_addr_seq", bad_addr, 0);
        check("fill_wdata", bad_data, 0);
        check("fill_flags", bad_flags, 0);
        check("fill_done_busy", bus.busy, 0);
        check("fill_done_ready", bus.cmd_ready, 1);
        check("fill_addr_hold", bus.mem_addr, 31999);
        for (int i = 0; i < 32000; i++) exp_ram[i] = 16'h0303;
        compare_ram("fill_ram");

        // Reset during a fill, at word 100.
        bus.cmd_op    = 1'b1;
        bus.cmd_color = 8'h5A;
        bus.cmd_valid = 1'b1;
        wait_accept();
        n = 0;
        while (bus.mem_addr != 15'd100 && n < 200) begin
            step();
            n++;
        end
        check("abort_reach100", 32'(n < 200), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_we", bus.mem_we, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_addr", bus.mem_addr, 0);
        check("abort_wdata", bus.mem_wdata, 0);
        step();
        check("abort_still_idle", bus.busy, 0);
        for (int i = 0; i <= 100; i++) exp_ram[i] = 16'h5A5A;
        compare_ram("abort_ram");

        plot_and_check(100, 50, 8'h99);
        plot_and_check(57, 13, 8'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
